// File: rtl/data_memory_ctrl.sv
// Handshaked RV32 data memory: wait-state latency, byte-lane stores, sign/zero-extended loads, error reporting.
module data_memory_ctrl #(
  parameter int unsigned SIZE      = 1024,
  parameter int unsigned LATENCY   = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WE,
  input  logic [31:0] REQ_ADDR,
  input  logic [1:0]  REQ_SIZE,
  input  logic        REQ_UNSIGNED,
  input  logic [31:0] REQ_WDATA,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic [31:0] RSP_RDATA,
  output logic        RSP_ERR
);

  localparam int unsigned IDX_W    = $clog2(SIZE);
  localparam logic [32:0] SPAN     = 33'(SIZE) << 2;
  localparam logic [3:0]  CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  if (LATENCY > 15) begin : g_bad_latency
    $error("data_memory_ctrl: LATENCY must be in 0..15");
  end
  if (SIZE < 2 || (SIZE & (SIZE - 1)) != 0) begin : g_bad_size
    $error("data_memory_ctrl: SIZE must be a power of two (>= 2)");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        we_q, uns_q;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  size_q;

  logic [31:0] mem [SIZE];

  logic        accept, commit, use_in;
  logic        acc_we, acc_uns;
  logic [31:0] acc_addr, acc_wdata;
  logic [1:0]  acc_size, acc_lane;
  logic [32:0] diff;
  logic        in_range, misalign, acc_err;
  logic [IDX_W-1:0] idx;
  logic [3:0]  be;
  logic [31:0] wd, mem_word, ld;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;

  assign accept = (state_q == S_IDLE) && REQ_VALID;
  // With zero latency the access commits on the accept edge itself, so it must use the live request.
  assign commit = (LATENCY == 0) ? accept : ((state_q == S_WAIT) && (cnt_q == 4'd0));
  assign use_in = (state_q == S_IDLE);

  assign acc_we    = use_in ? REQ_WE       : we_q;
  assign acc_uns   = use_in ? REQ_UNSIGNED : uns_q;
  assign acc_addr  = use_in ? REQ_ADDR     : addr_q;
  assign acc_wdata = use_in ? REQ_WDATA    : wdata_q;
  assign acc_size  = use_in ? REQ_SIZE     : size_q;
  assign acc_lane  = acc_addr[1:0];

  always_comb begin
    diff     = {1'b0, acc_addr} - {1'b0, BASE_ADDR};
    in_range = !diff[32] && ({1'b0, diff[31:0]} < SPAN);
    unique case (acc_size)
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = acc_addr[0];
      2'b10:   misalign = (acc_addr[1:0] != 2'b00);
      default: misalign = 1'b1;
    endcase
    acc_err = misalign || !in_range;
    idx     = diff[IDX_W+1:2];
  end

  always_comb begin
    unique case (acc_size)
      2'b00: begin
        be = 4'b0001 << acc_lane;
        wd = {4{acc_wdata[7:0]}};
      end
      2'b01: begin
        be = 4'b0011 << acc_lane;
        wd = {2{acc_wdata[15:0]}};
      end
      default: begin
        be = 4'b1111;
        wd = acc_wdata;
      end
    endcase
  end

  always_comb begin
    mem_word = mem[idx];
    unique case (acc_lane)
      2'd0:    ld_b = mem_word[7:0];
      2'd1:    ld_b = mem_word[15:8];
      2'd2:    ld_b = mem_word[23:16];
      default: ld_b = mem_word[31:24];
    endcase
    ld_h = acc_lane[1] ? mem_word[31:16] : mem_word[15:0];
    unique case (acc_size)
      2'b00:   ld = acc_uns ? {24'd0, ld_b} : {{24{ld_b[7]}}, ld_b};
      2'b01:   ld = acc_uns ? {16'd0, ld_h} : {{16{ld_h[15]}}, ld_h};
      default: ld = mem_word;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (commit) begin
      rdata_d = (acc_err || acc_we) ? 32'd0 : ld;
      err_d   = acc_err;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (REQ_VALID) begin
          if (LATENCY == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_RESP: begin
        if (RSP_READY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    REQ_READY = (state_q == S_IDLE);
    RSP_VALID = (state_q == S_RESP);
    RSP_RDATA = rdata_q;
    RSP_ERR   = err_q;
  end

  always_ff @(posedge CLK) begin
    if (accept) begin
      we_q    <= REQ_WE;
      uns_q   <= REQ_UNSIGNED;
      addr_q  <= REQ_ADDR;
      wdata_q <= REQ_WDATA;
      size_q  <= REQ_SIZE;
    end
  end

  always_ff @(posedge CLK) begin
    if (commit && acc_we && !acc_err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wd[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench for data_memory_ctrl: one LATENCY=1 instance and one LATENCY=3 instance.
module tb_data_memory_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rst3_n;
  logic        req_we, req_uns;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        v1, v3, rr1, rr3;
  logic        rdy1, rdy3, rv1, rv3, err1, err3;
  logic [31:0] rd1, rd3;

  data_memory_ctrl #(.SIZE(1024), .LATENCY(1), .BASE_ADDR(32'h0)) dut (
    .CLK(clk), .RESET_N(rst_n), .REQ_VALID(v1), .REQ_READY(rdy1), .REQ_WE(req_we),
    .REQ_ADDR(req_addr), .REQ_SIZE(req_size), .REQ_UNSIGNED(req_uns), .REQ_WDATA(req_wdata),
    .RSP_VALID(rv1), .RSP_READY(rr1), .RSP_RDATA(rd1), .RSP_ERR(err1)
  );

  data_memory_ctrl #(.SIZE(1024), .LATENCY(3), .BASE_ADDR(32'h0)) dut3 (
    .CLK(clk), .RESET_N(rst3_n), .REQ_VALID(v3), .REQ_READY(rdy3), .REQ_WE(req_we),
    .REQ_ADDR(req_addr), .REQ_SIZE(req_size), .REQ_UNSIGNED(req_uns), .REQ_WDATA(req_wdata),
    .RSP_VALID(rv3), .RSP_READY(rr3), .RSP_RDATA(rd3), .RSP_ERR(err3)
  );

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          lat;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t obs_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam logic [1:0] SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_R = 2'b11;

  // Drives one request, waits (bounded) for the response, records what the DUT returned.
  task automatic xfer(input bit sel, input logic we, input logic [31:0] addr,
                      input logic [1:0] size, input logic uns, input logic [31:0] wd);
    rsp_t o;
    int   n;
    @(negedge clk);
    req_we = we; req_addr = addr; req_size = size; req_uns = uns; req_wdata = wd;
    if (sel) v3 = 1'b1; else v1 = 1'b1;
    n = 0;
    while (!(sel ? rdy3 : rdy1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    v1 = 1'b0; v3 = 1'b0;
    o.lat = 1;
    while (!(sel ? rv3 : rv1) && o.lat < 40) begin
      @(negedge clk);
      o.lat++;
    end
    if (!(sel ? rv3 : rv1)) o.lat = -1;
    o.rd  = sel ? rd3 : rd1;
    o.err = sel ? err3 : err1;
    if (sel) rr3 = 1'b1; else rr1 = 1'b1;
    @(negedge clk);
    rr1 = 1'b0; rr3 = 1'b0;
    obs_q.push_back(o);
  endtask

  task automatic issue(input bit sel, input logic we, input logic [31:0] addr,
                       input logic [1:0] size, input logic uns, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err);
    rsp_t e;
    e.rd  = exp_rd;
    e.err = exp_err;
    e.lat = sel ? 4 : 2;
    exp_q.push_back(e);
    xfer(sel, we, addr, size, uns, wd);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({rdy1, rv1, err1, rd1} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_hold_l1: rdy=%b vld=%b err=%b rdata=%h, expected 1 0 0 00000000", rdy1, rv1, err1, rd1);
    end
    n_checks++;
    if ({rdy3, rv3, err3, rd3} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_hold_l3: rdy=%b vld=%b err=%b rdata=%h, expected 1 0 0 00000000", rdy3, rv3, err3, rd3);
    end
    rst_n = 1'b1; rst3_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({rdy1, rv1, err1, rd1} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_idle_l1: rdy=%b vld=%b err=%b rdata=%h, expected 1 0 0 00000000", rdy1, rv1, err1, rd1);
    end
    n_checks++;
    if ({rdy3, rv3, err3, rd3} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_idle_l3: rdy=%b vld=%b err=%b rdata=%h, expected 1 0 0 00000000", rdy3, rv3, err3, rd3);
    end
  endtask

  task automatic test_word();
    issue(0, 1'b1, 32'h40, SZ_W, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b0);
    issue(0, 1'b0, 32'h40, SZ_W, 1'b0, 32'h0,        32'hDEAD_BEEF, 1'b0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      rsp_t e, o;
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL word[%0d]: no response recorded, expected rd=%h", i, e.rd);
      end else begin
        o = obs_q.pop_front();
        if (o.rd !== e.rd || o.err !== e.err || o.lat !== e.lat) begin
          n_fail++;
          $display("FAIL word[%0d]: got rd=%h err=%b lat=%0d, expected rd=%h err=%b lat=%0d",
                   i, o.rd, o.err, o.lat, e.rd, e.err, e.lat);
        end
      end
    end
  endtask

  task automatic test_lanes();
    issue(0, 1'b1, 32'h41,   SZ_B, 1'b0, 32'h0000_0012, 32'h0, 1'b0);
    issue(0, 1'b1, 32'h42,   SZ_H, 1'b0, 32'h0000_ABCD, 32'h0, 1'b0);
    issue(0, 1'b0, 32'h40,   SZ_W, 1'b0, 32'h0,         32'hABCD_12EF, 1'b0);
    issue(0, 1'b1, 32'hFFC,  SZ_W, 1'b0, 32'h89AB_CDEF, 32'h0, 1'b0);
    issue(0, 1'b0, 32'hFFE,  SZ_H, 1'b0, 32'h0,         32'hFFFF_89AB, 1'b0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      rsp_t e, o;
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL lanes[%0d]: no response recorded, expected rd=%h", i, e.rd);
      end else begin
        o = obs_q.pop_front();
        if (o.rd !== e.rd || o.err !== e.err || o.lat !== e.lat) begin
          n_fail++;
          $display("FAIL lanes[%0d]: got rd=%h err=%b lat=%0d, expected rd=%h err=%b lat=%0d",
                   i, o.rd, o.err, o.lat, e.rd, e.err, e.lat);
        end
      end
    end
  endtask

  task automatic test_loads();
    issue(0, 1'b0, 32'h43, SZ_B, 1'b0, 32'h0, 32'hFFFF_FFAB, 1'b0);
    issue(0, 1'b0, 32'h43, SZ_B, 1'b1, 32'h0, 32'h0000_00AB, 1'b0);
    issue(0, 1'b0, 32'h42, SZ_H, 1'b0, 32'h0, 32'hFFFF_ABCD, 1'b0);
    issue(0, 1'b0, 32'h42, SZ_H, 1'b1, 32'h0, 32'h0000_ABCD, 1'b0);
    issue(0, 1'b0, 32'h41, SZ_B, 1'b0, 32'h0, 32'h0000_0012, 1'b0);
    issue(0, 1'b0, 32'h40, SZ_B, 1'b0, 32'h0, 32'hFFFF_FFEF, 1'b0);
    issue(0, 1'b0, 32'h40, SZ_H, 1'b1, 32'h0, 32'h0000_12EF, 1'b0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      rsp_t e, o;
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL loads[%0d]: no response recorded, expected rd=%h", i, e.rd);
      end else begin
        o = obs_q.pop_front();
        if (o.rd !== e.rd || o.err !== e.err || o.lat !== e.lat) begin
          n_fail++;
          $display("FAIL loads[%0d]: got rd=%h err=%b lat=%0d, expected rd=%h err=%b lat=%0d",
                   i, o.rd, o.err, o.lat, e.rd, e.err, e.lat);
        end
      end
    end
  endtask

  task automatic test_errors();
    issue(0, 1'b0, 32'h42,        SZ_W, 1'b0, 32'h0,         32'h0, 1'b1);
    issue(0, 1'b1, 32'h41,        SZ_H, 1'b0, 32'h0000_FFFF, 32'h0, 1'b1);
    issue(0, 1'b0, 32'h40,        SZ_W, 1'b0, 32'h0,         32'hABCD_12EF, 1'b0);
    issue(0, 1'b0, 32'h1000,      SZ_W, 1'b0, 32'h0,         32'h0, 1'b1);
    issue(0, 1'b1, 32'h1000,      SZ_W, 1'b0, 32'h1234_5678, 32'h0, 1'b1);
    issue(0, 1'b0, 32'h1003,      SZ_B, 1'b0, 32'h0,         32'h0, 1'b1);
    issue(0, 1'b0, 32'hFFFF_FFFC, SZ_W, 1'b0, 32'h0,         32'h0, 1'b1);
    issue(0, 1'b1, 32'h40,        SZ_R, 1'b0, 32'h5555_5555, 32'h0, 1'b1);
    issue(0, 1'b0, 32'h40,        SZ_W, 1'b0, 32'h0,         32'hABCD_12EF, 1'b0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      rsp_t e, o;
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL errors[%0d]: no response recorded, expected rd=%h", i, e.rd);
      end else begin
        o = obs_q.pop_front();
        if (o.rd !== e.rd || o.err !== e.err || o.lat !== e.lat) begin
          n_fail++;
          $display("FAIL errors[%0d]: got rd=%h err=%b lat=%0d, expected rd=%h err=%b lat=%0d",
                   i, o.rd, o.err, o.lat, e.rd, e.err, e.lat);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    @(negedge clk);
    req_we = 1'b0; req_addr = 32'h40; req_size = SZ_W; req_uns = 1'b0; req_wdata = 32'h0;
    v1 = 1'b1;
    @(negedge clk);
    v1 = 1'b0;
    n = 0;
    while (!rv1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    // A second request arrives with different fields while the first response is held off.
    req_addr = 32'hFFC; v1 = 1'b1;
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if ({rv1, rdy1, err1, rd1} !== {1'b1, 1'b0, 1'b0, 32'hABCD_12EF}) begin
        n_fail++;
        $display("FAIL backpressure[%0d]: vld=%b rdy=%b err=%b rdata=%h, expected 1 0 0 abcd12ef",
                 c, rv1, rdy1, err1, rd1);
      end
      @(negedge clk);
    end
    rr1 = 1'b1;
    @(negedge clk);
    rr1 = 1'b0;
    n_checks++;
    if ({rdy1, rv1} !== 2'b10) begin
      n_fail++;
      $display("FAIL no_reaccept: rdy=%b vld=%b, expected rdy=1 vld=0", rdy1, rv1);
    end
    @(negedge clk);
    v1 = 1'b0;
    n_checks++;
    if (rdy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL second_accept: rdy=%b, expected 0", rdy1);
    end
    n = 0;
    while (!rv1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if ({rv1, err1, rd1} !== {1'b1, 1'b0, 32'h89AB_CDEF}) begin
      n_fail++;
      $display("FAIL second_rsp: vld=%b err=%b rdata=%h, expected 1 0 89abcdef", rv1, err1, rd1);
    end
    rr1 = 1'b1;
    @(negedge clk);
    rr1 = 1'b0;
  endtask

  task automatic test_reset_mid();
    issue(1, 1'b1, 32'h80, SZ_W, 1'b0, 32'h2222_2222, 32'h0, 1'b0);
    issue(1, 1'b0, 32'h80, SZ_W, 1'b0, 32'h0,         32'h2222_2222, 1'b0);
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h80; req_size = SZ_W; req_uns = 1'b0; req_wdata = 32'h1111_1111;
    v3 = 1'b1;
    @(negedge clk);
    v3 = 1'b0;
    @(negedge clk);
    #2 rst3_n = 1'b0;
    #1;
    n_checks++;
    if ({rdy3, rv3, err3, rd3} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL async_reset: rdy=%b vld=%b err=%b rdata=%h, expected 1 0 0 00000000", rdy3, rv3, err3, rd3);
    end
    @(negedge clk);
    rst3_n = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    if ({rdy3, rv3} !== 2'b10) begin
      n_fail++;
      $display("FAIL dropped_req: rdy=%b vld=%b, expected rdy=1 vld=0", rdy3, rv3);
    end
    issue(1, 1'b0, 32'h80, SZ_W, 1'b0, 32'h0, 32'h2222_2222, 1'b0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      rsp_t e, o;
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL reset_mid[%0d]: no response recorded, expected rd=%h", i, e.rd);
      end else begin
        o = obs_q.pop_front();
        if (o.rd !== e.rd || o.err !== e.err || o.lat !== e.lat) begin
          n_fail++;
          $display("FAIL reset_mid[%0d]: got rd=%h err=%b lat=%0d, expected rd=%h err=%b lat=%0d",
                   i, o.rd, o.err, o.lat, e.rd, e.err, e.lat);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; rst3_n = 1'b0;
    v1 = 1'b0; v3 = 1'b0; rr1 = 1'b0; rr3 = 1'b0;
    req_we = 1'b0; req_addr = 32'h0; req_size = 2'b00; req_uns = 1'b0; req_wdata = 32'h0;
    test_reset();
    test_word();
    test_lanes();
    test_loads();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
